hazard_scoreboard: RTL

Next-generation hazard unit for the dual scalar/vector RISC pipeline (F/D/E/M/W).
- Generates forwarding selects per register class.
- Detects load-use hazards per class.
- Adds a per-vector-register busy scoreboard for multi-cycle vector ops (VMUL/VMAC), which cannot forward and hold their destination for VLAT cycles.
- Sits beside the datapath; drives stall/flush of the F/D and D/E pipeline registers and the E-stage operand muxes.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/vreg_busy_counter.sv | 40 ++++
 rtl/hazard_scoreboard.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the scalar/vector hazard unit.
//   FWD_*        : E-stage operand mux select encodings
//   VEC_FUNCT7   : funct7 value marking vector-class opcodes
//   DEFAULT_REG_AW: default register index width for both classes
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_W  = 2'b01;  // operand from W-stage result
    localparam logic [1:0] FWD_M  = 2'b10;  // operand from M-stage result

    localparam logic [6:0] VEC_FUNCT7 = 7'b1010101;

    localparam int DEFAULT_REG_AW = 5;

endpackage

// File: rtl/vreg_busy_counter.sv
// Busy timer for one vector register.
//   clk, rst : clock, synchronous active-high reset
//   load     : destination claimed by a multi-cycle vector op this cycle
//   busy     : register result not yet written back
// Loading has priority over the per-cycle decrement.
module vreg_busy_counter #(
    parameter int CNT_W = 4,
    parameter int VLAT  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // NOTE: cnt_d takes its hold value first so every path assigns it and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(VLAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the dual scalar/vector F/D/E/M/W pipeline.
//   Inputs : D/E/M/W register indices, class flags, write enables, load and
//            multi-cycle vector issue flags, taken-branch flag from E.
//   Outputs: per-class E operand forwarding selects, F/D stall, D/E flush,
//            per-vector-register busy flags, saturating stall-cycle counter.
// Forwarding and stall are combinational; the vector busy scoreboard and the
// stall counter are the only state (one cycle latency).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW  = DEFAULT_REG_AW,
    parameter int VLAT    = 4,
    parameter int CNT_W   = 4,
    parameter bit V0_ZERO = 1'b0,
    parameter int PERF_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_AW-1:0]     Rs1D,
    input  logic [REG_AW-1:0]     Rs2D,
    input  logic [REG_AW-1:0]     RdD,
    input  logic                  VecD,
    input  logic                  WriteD,
    input  logic [REG_AW-1:0]     Rs1E,
    input  logic [REG_AW-1:0]     Rs2E,
    input  logic [REG_AW-1:0]     RdE,
    input  logic                  VecE,
    input  logic                  ResultSrcE0,
    input  logic                  VMulIssueE,
    input  logic [REG_AW-1:0]     RdM,
    input  logic [REG_AW-1:0]     RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  VecM,
    input  logic                  VecW,
    input  logic                  PCSrcE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic [1:0]            VForwardAE,
    output logic [1:0]            VForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [2**REG_AW-1:0]  VBusy,
    output logic [PERF_W-1:0]     StallCycles
);

    localparam int NREG = 2**REG_AW;

    // An index takes part in hazards unless it names a hardwired-zero register.
    function automatic logic live(input logic [REG_AW-1:0] idx, input logic vec);
        return (idx != '0) || (vec && !V0_ZERO);
    endfunction

    // Select for one E operand of one class; M wins over W.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, input logic cls);
        logic [1:0] sel;
        sel = FWD_RF;
        if (VecE == cls && live(rs, cls)) begin
            if (RegWriteM && VecM == cls && rs == RdM) begin
                sel = FWD_M;
            end else if (RegWriteW && VecW == cls && rs == RdW) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    logic              lw_stall;
    logic              sb_stall;
    logic              issue_stall;
    logic              stall;
    logic              vmul_load;
    logic [NREG-1:0]   vload;
    logic [PERF_W-1:0] stall_cycles_d;
    logic [PERF_W-1:0] stall_cycles_q;

    always_comb begin
        lw_stall = ResultSrcE0 && (VecE == VecD) && live(RdE, VecE)
                   && (RdE == Rs1D || RdE == Rs2D);

        sb_stall = VecD && ((VBusy[Rs1D] && live(Rs1D, 1'b1))
                         || (VBusy[Rs2D] && live(Rs2D, 1'b1))
                         || (WriteD && VBusy[RdD] && live(RdD, 1'b1)));

        // The busy counter for RdE only becomes visible next cycle, so an
        // issuing vector op must block a dependent D instruction directly.
        issue_stall = VMulIssueE && VecD && live(RdE, 1'b1)
                      && (RdE == Rs1D || RdE == Rs2D || (WriteD && RdE == RdD));

        stall = lw_stall || sb_stall || issue_stall;

        // A taken branch does not cancel the op already in E, so it still claims RdE.
        vmul_load = VMulIssueE && !lw_stall && live(RdE, 1'b1);

        ForwardAE  = FWD_RF;
        ForwardBE  = FWD_RF;
        VForwardAE = FWD_RF;
        VForwardBE = FWD_RF;
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        if (!rst) begin
            ForwardAE  = fwd_sel(Rs1E, 1'b0);
            ForwardBE  = fwd_sel(Rs2E, 1'b0);
            VForwardAE = fwd_sel(Rs1E, 1'b1);
            VForwardBE = fwd_sel(Rs2E, 1'b1);
            StallF     = stall && !PCSrcE;
            StallD     = stall && !PCSrcE;
            FlushD     = PCSrcE;
            FlushE     = stall || PCSrcE;
        end

        stall_cycles_d = stall_cycles_q;
        if (StallD && stall_cycles_q != '1) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_busy
        assign vload[r] = vmul_load && (RdE == REG_AW'(r));

        vreg_busy_counter #(
            .CNT_W (CNT_W),
            .VLAT  (VLAT)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .load (vload[r]),
            .busy (VBusy[r])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign StallCycles = stall_cycles_q;

endmodule
